// File: rtl/difftest_step_ctrl.sv
// Difftest step controller: batches per-core commit steps into host step requests,
// tracks cycle/instruction counts and latches a sticky termination reason.
module difftest_step_ctrl #(
    parameter int NUM_CORES    = 1,
    parameter int STEP_WIDTH   = 8,
    parameter int ACC_WIDTH    = 24,
    parameter int BATCH_STEPS  = 64,
    parameter int FLUSH_CYCLES = 256
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_CORES*STEP_WIDTH-1:0] core_step,
    input  logic [63:0]                     cfg_max_cycles,
    input  logic [63:0]                     cfg_max_instrs,
    output logic                            req_valid,
    output logic [ACC_WIDTH-1:0]            req_step,
    input  logic                            req_ready,
    input  logic                            host_result_valid,
    input  logic [31:0]                     host_result_code,
    output logic                            init_pulse,
    output logic                            stall,
    output logic [63:0]                     cycle_count,
    output logic [63:0]                     instr_count,
    output logic                            done,
    output logic [1:0]                      exit_reason,
    output logic [31:0]                     exit_code
);

    localparam int SINCE_W = $clog2(FLUSH_CYCLES + 1);
    localparam int AW1     = ACC_WIDTH + 1;
    // Stall once one more worst-case cycle of commits could overflow acc.
    localparam logic [AW1-1:0] STALL_TH =
        {1'b0, {ACC_WIDTH{1'b1}}} - AW1'(NUM_CORES * (2**STEP_WIDTH - 1));

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DONE} state_t;
    state_t state, state_nxt;

    logic [NUM_CORES*STEP_WIDTH-1:0] step_d;
    logic [ACC_WIDTH-1:0]            acc, pend_step, step_sum;
    logic                            pend_valid;
    logic [SINCE_W-1:0]              since;
    logic run, fire, load, term_fail, term_instr, term_cycle, term;

    always_comb begin
        step_sum = '0;
        for (int i = 0; i < NUM_CORES; i++)
            step_sum = step_sum + ACC_WIDTH'(step_d[i*STEP_WIDTH +: STEP_WIDTH]);
    end

    assign run        = (state == ST_RUN);
    assign req_valid  = pend_valid & run;
    assign req_step   = pend_step;
    assign fire       = req_valid & req_ready;
    assign init_pulse = (state == ST_INIT) & ~reset;
    assign done       = (state == ST_DONE);
    assign stall      = {1'b0, acc} >= STALL_TH;

    // A fire frees the slot in the same cycle, so back-to-back requests are possible.
    assign load = run && (!pend_valid || fire) &&
                  (acc >= ACC_WIDTH'(BATCH_STEPS) ||
                   (acc != '0 && since >= SINCE_W'(FLUSH_CYCLES)));

    assign term_fail  = host_result_valid && (host_result_code != 32'd0);
    assign term_instr = (cfg_max_instrs != 64'd0) && (instr_count >= cfg_max_instrs);
    assign term_cycle = (cfg_max_cycles != 64'd0) && (cycle_count >= cfg_max_cycles);
    assign term       = run && (term_fail || term_instr || term_cycle);

    always_ff @(posedge clock) begin
        if (reset) state <= ST_INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: state_nxt = ST_RUN;
            ST_RUN:  if (term) state_nxt = ST_DONE;
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            step_d      <= '0;
            acc         <= '0;
            pend_step   <= '0;
            pend_valid  <= 1'b0;
            since       <= '0;
            cycle_count <= '0;
            instr_count <= '0;
            exit_reason <= 2'd0;
            exit_code   <= 32'd0;
        end else begin
            step_d <= core_step;
            // The terminating cycle is not counted, so the count freezes at the limit.
            if (state != ST_DONE && !term)
                cycle_count <= cycle_count + 64'd1;
            if (run) begin
                if (load) begin
                    pend_step  <= acc;
                    pend_valid <= 1'b1;
                    acc        <= step_sum;
                    since      <= '0;
                end else begin
                    acc <= acc + step_sum;
                    if (since < SINCE_W'(FLUSH_CYCLES))
                        since <= since + SINCE_W'(1);
                    if (fire)
                        pend_valid <= 1'b0;
                end
                if (fire)
                    instr_count <= instr_count + 64'(pend_step);
                if (term) begin
                    if (term_fail) begin
                        exit_reason <= 2'd1;
                        exit_code   <= host_result_code;
                    end else if (term_instr) begin
                        exit_reason <= 2'd2;
                        exit_code   <= 32'hFF;
                    end else begin
                        exit_reason <= 2'd3;
                        exit_code   <= 32'd0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_difftest_step_ctrl.sv
// Bench for difftest_step_ctrl: cycle model of the batching/termination rules plus
// directed scenarios with hand-computed expectations.
module tb_difftest_step_ctrl;

    localparam int NC = 2, SW = 8, AW = 24, BATCH = 64, FLUSH = 256;
    localparam logic [63:0] STALL_LIM = 64'((1 << AW) - 1 - NC * 255);

    logic              clock = 1'b0, reset = 1'b1;
    logic [NC*SW-1:0]  core_step = '0;
    logic [63:0]       cfg_max_cycles = '0, cfg_max_instrs = '0;
    logic              req_ready = 1'b0, host_result_valid = 1'b0;
    logic [31:0]       host_result_code = '0;
    logic              req_valid, init_pulse, stall, done;
    logic [AW-1:0]     req_step;
    logic [63:0]       cycle_count, instr_count;
    logic [1:0]        exit_reason;
    logic [31:0]       exit_code;

    difftest_step_ctrl #(.NUM_CORES(NC), .STEP_WIDTH(SW), .ACC_WIDTH(AW),
                         .BATCH_STEPS(BATCH), .FLUSH_CYCLES(FLUSH)) dut (
        .clock(clock), .reset(reset), .core_step(core_step),
        .cfg_max_cycles(cfg_max_cycles), .cfg_max_instrs(cfg_max_instrs),
        .req_valid(req_valid), .req_step(req_step), .req_ready(req_ready),
        .host_result_valid(host_result_valid), .host_result_code(host_result_code),
        .init_pulse(init_pulse), .stall(stall), .cycle_count(cycle_count),
        .instr_count(instr_count), .done(done), .exit_reason(exit_reason),
        .exit_code(exit_code));

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    bit started = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 = first cycle after reset, 1 = running, 2 = finished.
    int          m_phase;
    logic [63:0] m_acc, m_pstep, m_instr, m_cyc, m_since, m_sum;
    logic        m_pv, m_take, m_launch;
    logic [1:0]  m_reason, m_why;
    logic [31:0] m_code;
    logic [NC*SW-1:0] m_stepd;

    always_comb begin
        m_sum = '0;
        for (int i = 0; i < NC; i++) m_sum = m_sum + 64'(m_stepd[i*SW +: SW]);
        m_take   = m_pv && (m_phase == 1) && req_ready;
        m_launch = (m_phase == 1) && (!m_pv || m_take) &&
                   (m_acc >= 64'(BATCH) || (m_acc != 0 && m_since >= 64'(FLUSH)));
        m_why = 2'd0;
        if (host_result_valid && host_result_code != 0)        m_why = 2'd1;
        else if (cfg_max_instrs != 0 && m_instr >= cfg_max_instrs) m_why = 2'd2;
        else if (cfg_max_cycles != 0 && m_cyc >= cfg_max_cycles)   m_why = 2'd3;
    end

    always @(posedge clock) begin
        if (reset) begin
            m_phase <= 0; m_acc <= 0; m_pstep <= 0; m_instr <= 0; m_cyc <= 0;
            m_since <= 0; m_pv <= 0; m_reason <= 0; m_code <= 0; m_stepd <= '0;
        end else begin
            m_stepd <= core_step;
            if (m_phase == 0) begin
                m_phase <= 1;
                m_cyc   <= m_cyc + 1;
            end else if (m_phase == 1) begin
                if (m_launch) begin
                    m_pstep <= m_acc; m_pv <= 1; m_acc <= m_sum; m_since <= 0;
                end else begin
                    m_acc <= m_acc + m_sum; m_since <= m_since + 1;
                    if (m_take) m_pv <= 0;
                end
                if (m_take) m_instr <= m_instr + m_pstep;
                if (m_why != 0) begin
                    m_phase  <= 2;
                    m_reason <= m_why;
                    m_code   <= (m_why == 2'd1) ? host_result_code :
                                (m_why == 2'd2) ? 32'hFF : 32'd0;
                end else begin
                    m_cyc <= m_cyc + 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("req_valid",   64'(req_valid),   64'(m_pv && m_phase == 1));
            chk("req_step",    64'(req_step),    m_pstep);
            chk("init_pulse",  64'(init_pulse),  64'(m_phase == 0 && !reset));
            chk("stall",       64'(stall),       64'(m_acc >= STALL_LIM));
            chk("cycle_count", cycle_count,      m_cyc);
            chk("instr_count", instr_count,      m_instr);
            chk("done",        64'(done),        64'(m_phase == 2));
            chk("exit_reason", 64'(exit_reason), 64'(m_reason));
            chk("exit_code",   64'(exit_code),   64'(m_code));
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    // Leaves the bench in the single INIT cycle after reset release.
    task automatic do_reset();
        reset = 1'b1; core_step = '0; req_ready = 1'b0;
        host_result_valid = 1'b0; host_result_code = '0;
        tick(); started = 1'b1;
        tick(); reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses, stale;

        // Two cores, single commit burst of 40+30.
        do_reset();
        @(negedge clock);
        chk("t1_init_pulse", 64'(init_pulse), 64'd1);
        chk("t1_cycle0", cycle_count, 64'd0);
        tick(); core_step = {8'd30, 8'd40};
        tick(); core_step = '0;
        tick();
        @(negedge clock); chk("t1_no_req_yet", 64'(req_valid), 64'd0);
        tick(); req_ready = 1'b1;
        @(negedge clock);
        chk("t1_req_valid", 64'(req_valid), 64'd1);
        chk("t1_req_step", 64'(req_step), 64'd70);
        tick(); req_ready = 1'b0;
        @(negedge clock); chk("t1_instr", instr_count, 64'd70);

        // Backpressure: 16 steps/cycle for 20 cycles, ready low for 10 cycles.
        do_reset();
        tick(); core_step = {8'd8, 8'd8};
        repeat (6) tick();
        @(negedge clock); chk("t2_first_req", 64'(req_step), 64'd64);
        repeat (9) tick();
        @(negedge clock);
        chk("t2_held_step", 64'(req_step), 64'd64);
        chk("t2_held_valid", 64'(req_valid), 64'd1);
        tick(); req_ready = 1'b1;
        tick();
        @(negedge clock); chk("t2_remainder", 64'(req_step), 64'd176);
        repeat (3) tick(); core_step = '0;
        for (int i = 0; i < 400 && instr_count != 64'd320; i++) tick();
        chk("t2_total", instr_count, 64'd320);
        req_ready = 1'b0;

        // Flush timeout: a lone step of 5.
        do_reset();
        tick(); core_step = {8'd0, 8'd5};
        tick(); core_step = '0;
        repeat (255) tick();
        @(negedge clock); chk("t3_no_early_flush", 64'(req_valid), 64'd0);
        tick();
        @(negedge clock);
        chk("t3_flush_valid", 64'(req_valid), 64'd1);
        chk("t3_flush_step", 64'(req_step), 64'd5);
        req_ready = 1'b1;
        tick(); req_ready = 1'b0;
        @(negedge clock); chk("t3_instr", instr_count, 64'd5);

        // Cycle limit of 100.
        cfg_max_cycles = 64'd100;
        do_reset();
        repeat (100) tick();
        @(negedge clock);
        chk("t4_not_done", 64'(done), 64'd0);
        chk("t4_cycle100", cycle_count, 64'd100);
        tick();
        @(negedge clock);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_reason", 64'(exit_reason), 64'd3);
        chk("t4_code", 64'(exit_code), 64'd0);
        repeat (5) tick();
        @(negedge clock); chk("t4_frozen", cycle_count, 64'd100);
        cfg_max_cycles = '0;

        // Host failure beats instruction limit; the same-cycle request still counts.
        cfg_max_instrs = 64'd64;
        do_reset();
        tick(); core_step = {8'd32, 8'd32};
        tick(); core_step = '0;
        tick();
        tick(); req_ready = 1'b1; host_result_valid = 1'b1; host_result_code = 32'd7;
        @(negedge clock); chk("t5_req_valid", 64'(req_valid), 64'd1);
        tick(); req_ready = 1'b0; host_result_valid = 1'b0; host_result_code = '0;
        @(negedge clock);
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_reason", 64'(exit_reason), 64'd1);
        chk("t5_code", 64'(exit_code), 64'd7);
        chk("t5_instr", instr_count, 64'd64);
        cfg_max_instrs = '0;

        // Reset while a request is pending and acc holds 30.
        do_reset();
        tick(); core_step = {8'd30, 8'd40};
        tick(); core_step = '0;
        tick();
        tick(); core_step = {8'd10, 8'd20};
        tick(); core_step = '0;
        tick();
        @(negedge clock); chk("t6_pending", 64'(req_valid), 64'd1);
        reset = 1'b1;
        tick();
        @(negedge clock);
        chk("t6_rst_valid", 64'(req_valid), 64'd0);
        chk("t6_rst_step", 64'(req_step), 64'd0);
        chk("t6_rst_init", 64'(init_pulse), 64'd0);
        chk("t6_rst_cycle", cycle_count, 64'd0);
        chk("t6_rst_instr", instr_count, 64'd0);
        tick(); reset = 1'b0; req_ready = 1'b1;
        pulses = 0; stale = 0;
        repeat (30) begin
            @(negedge clock);
            if (init_pulse) pulses++;
            if (req_valid)  stale++;
        end
        chk("t6_init_once", 64'(pulses), 64'd1);
        chk("t6_no_stale", 64'(stale), 64'd0);
        req_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
